// File: rtl/free_list_mp.sv
// Physical-register free list for a multi-lane rename stage.
// Holds DEPTH free tags in a circular buffer. Rename pops up to ALLOC_W tags
// per cycle and retirement pushes up to FREE_W tags per cycle. Checkpoints
// snapshot the read pointer so that a mispredict can hand back the tags
// allocated on the wrong path.
module free_list_mp #(
  parameter int NUM_PREGS = 128,
  parameter int NUM_AREGS = 32,
  parameter int ALLOC_W   = 2,
  parameter int FREE_W    = 2,
  parameter int NUM_CKPT  = 4,
  localparam int DEPTH = NUM_PREGS - NUM_AREGS,
  localparam int TAG_W = $clog2(NUM_PREGS),
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int AC_W  = $clog2(ALLOC_W + 1),
  localparam int ID_W  = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      alloc_valid,
  input  logic [AC_W-1:0]           alloc_cnt,
  output logic                      alloc_ready,
  output logic [ALLOC_W*TAG_W-1:0]  alloc_tag,
  input  logic [FREE_W-1:0]         free_valid,
  input  logic [FREE_W*TAG_W-1:0]   free_tag,
  input  logic                      ckpt_save,
  input  logic                      ckpt_restore,
  input  logic [ID_W-1:0]           ckpt_id,
  input  logic [NUM_CKPT-1:0]       ckpt_release,
  input  logic [NUM_CKPT-1:0]       ckpt_kill,
  output logic [CNT_W-1:0]          free_count,
  output logic [NUM_CKPT-1:0]       ckpt_valid,
  output logic                      overflow_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Circular pointer advance; n never exceeds one lane group, so one
  // conditional subtract is enough even when DEPTH is not a power of two.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  // Since counters count outstanding allocations and can never exceed DEPTH.
  function automatic logic [CNT_W-1:0] since_add(input logic [CNT_W-1:0] a, input int n);
    int s;
    s = int'(a) + n;
    if (s > DEPTH) s = DEPTH;
    return CNT_W'(s);
  endfunction

  // Older slots always hold a larger count than the restored one; clamp anyway.
  function automatic logic [CNT_W-1:0] since_sub(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    if (a >= b) return a - b;
    return '0;
  endfunction

  logic [TAG_W-1:0] list_q [DEPTH];
  logic [TAG_W-1:0] list_d [DEPTH];
  logic [PTR_W-1:0] r_ptr_q, r_ptr_d;
  logic [PTR_W-1:0] w_ptr_q, w_ptr_d;
  logic [CNT_W-1:0] free_count_q, free_count_d;
  logic             overflow_err_q, overflow_err_d;
  logic [NUM_CKPT-1:0] ckpt_valid_q, ckpt_valid_d;
  logic [PTR_W-1:0] ckpt_rptr_q  [NUM_CKPT];
  logic [PTR_W-1:0] ckpt_rptr_d  [NUM_CKPT];
  logic [CNT_W-1:0] ckpt_since_q [NUM_CKPT];
  logic [CNT_W-1:0] ckpt_since_d [NUM_CKPT];

  logic             restore_vld;
  logic             alloc_fire;
  int               alloc_n;
  logic [PTR_W-1:0] r_ptr_alloc;
  logic [CNT_W-1:0] restored_since;

  assign alloc_ready  = (int'(free_count_q) >= ALLOC_W);
  assign free_count   = free_count_q;
  assign ckpt_valid   = ckpt_valid_q;
  assign overflow_err = overflow_err_q;

  // Allocation decision: a valid restore wins over rename in the same cycle.
  always_comb begin
    restore_vld    = ckpt_restore & ckpt_valid_q[ckpt_id];
    restored_since = ckpt_since_q[ckpt_id];
    alloc_fire     = alloc_valid & alloc_ready & ~restore_vld;
    alloc_n        = 0;
    if (alloc_fire) begin
      alloc_n = (int'(alloc_cnt) > ALLOC_W) ? ALLOC_W : int'(alloc_cnt);
    end
    r_ptr_alloc = ptr_add(r_ptr_q, alloc_n);
  end

  // Present the next ALLOC_W tags starting at the read pointer.
  always_comb begin
    alloc_tag = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      alloc_tag[i*TAG_W +: TAG_W] = list_q[ptr_add(r_ptr_q, i)];
    end
  end

  // Pointer/count update and compaction of retired tags onto the tail.
  always_comb begin
    int cnt;
    logic [PTR_W-1:0] wp;
    list_d         = list_q;
    wp             = w_ptr_q;
    overflow_err_d = overflow_err_q;
    if (restore_vld) begin
      cnt     = int'(free_count_q) + int'(restored_since);
      r_ptr_d = ckpt_rptr_q[ckpt_id];
    end else begin
      cnt     = int'(free_count_q) - alloc_n;
      r_ptr_d = r_ptr_alloc;
    end
    for (int i = 0; i < FREE_W; i++) begin
      if (free_valid[i] && (free_tag[i*TAG_W +: TAG_W] != '0)) begin
        if (cnt < DEPTH) begin
          list_d[wp] = free_tag[i*TAG_W +: TAG_W];
          wp         = ptr_add(wp, 1);
          cnt        = cnt + 1;
        end else begin
          overflow_err_d = 1'b1;
        end
      end
    end
    w_ptr_d      = wp;
    free_count_d = CNT_W'(cnt);
  end

  // Checkpoint slots: save, since tracking, restore/kill and release.
  always_comb begin
    for (int s = 0; s < NUM_CKPT; s++) begin
      ckpt_valid_d[s] = ckpt_valid_q[s];
      ckpt_rptr_d[s]  = ckpt_rptr_q[s];
      ckpt_since_d[s] = ckpt_since_q[s];
      if (restore_vld) begin
        if ((int'(ckpt_id) == s) || ckpt_kill[s]) begin
          ckpt_valid_d[s] = 1'b0;
        end else if (ckpt_valid_q[s]) begin
          ckpt_since_d[s] = since_sub(ckpt_since_q[s], restored_since);
        end
      end else if (ckpt_save && (int'(ckpt_id) == s)) begin
        ckpt_valid_d[s] = 1'b1;
        ckpt_rptr_d[s]  = r_ptr_alloc;
        ckpt_since_d[s] = '0;
      end else if (ckpt_valid_q[s]) begin
        ckpt_since_d[s] = since_add(ckpt_since_q[s], alloc_n);
      end
      if (ckpt_release[s]) ckpt_valid_d[s] = 1'b0;
    end
  end

  // State registers; reset refills the list with every non-architectural tag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr_q        <= '0;
      w_ptr_q        <= '0;
      free_count_q   <= CNT_W'(DEPTH);
      overflow_err_q <= 1'b0;
      ckpt_valid_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        list_q[i] <= TAG_W'(NUM_AREGS + i);
      end
      for (int s = 0; s < NUM_CKPT; s++) begin
        ckpt_rptr_q[s]  <= '0;
        ckpt_since_q[s] <= '0;
      end
    end else begin
      r_ptr_q        <= r_ptr_d;
      w_ptr_q        <= w_ptr_d;
      free_count_q   <= free_count_d;
      overflow_err_q <= overflow_err_d;
      ckpt_valid_q   <= ckpt_valid_d;
      list_q         <= list_d;
      for (int s = 0; s < NUM_CKPT; s++) begin
        ckpt_rptr_q[s]  <= ckpt_rptr_d[s];
        ckpt_since_q[s] <= ckpt_since_d[s];
      end
    end
  end

endmodule

// File: doc/free_list_mp.md
FREE_LIST_MP -- requirements
Module: free_list_mp

Interface
REQ-001 Parameter NUM_PREGS, default 128: physical register count.
REQ-002 Parameter NUM_AREGS, default 32: architectural register count. Tags 0..NUM_AREGS-1 are never on the list at reset.
REQ-003 Parameter ALLOC_W, default 2: allocation lanes per cycle.
REQ-004 Parameter FREE_W, default 2: free lanes per cycle.
REQ-005 Parameter NUM_CKPT, default 4: checkpoint slots.
REQ-006 Derived values: DEPTH = NUM_PREGS-NUM_AREGS, TAG_W = $clog2(NUM_PREGS), CNT_W = $clog2(DEPTH+1).
REQ-007 clk  in  1  Single clock; all state updates on the rising edge.
REQ-008 reset_n  in  1  Reset; synchronous and active-low.
REQ-009 alloc_valid  in  1  Rename requests allocation this cycle.
REQ-010 alloc_cnt  in  $clog2(ALLOC_W+1)  Number of tags taken, using lanes 0..alloc_cnt-1.
REQ-011 alloc_ready  out  1  High when free_count >= ALLOC_W.
REQ-012 alloc_tag  out  ALLOC_W x TAG_W  Lane i = list[(r_ptr+i) mod DEPTH]; combinational.
REQ-013 free_valid  in  FREE_W  Per-lane free strobe from the ROB.
REQ-014 free_tag  in  FREE_W x TAG_W  Tags returned by retirement.
REQ-015 ckpt_save  in  1  Save a snapshot into slot ckpt_id.
REQ-016 ckpt_restore  in  1  Recover from a mispredict using slot ckpt_id.
REQ-017 ckpt_id  in  $clog2(NUM_CKPT)  Slot selector.
REQ-018 ckpt_release  in  NUM_CKPT  Mask of slots to invalidate; a branch resolved correctly.
REQ-019 ckpt_kill  in  NUM_CKPT  Mask of younger slots to invalidate on restore.
REQ-020 free_count  out  CNT_W  Entries currently free.
REQ-021 ckpt_valid  out  NUM_CKPT  Per-slot valid.
REQ-022 overflow_err  out  1  Sticky flag: a free was dropped because the list was full.

Function
REQ-023 The list SHALL be a circular buffer of DEPTH entries with r_ptr and w_ptr that wrap from DEPTH-1 to 0 (DEPTH need not be a power of 2).
REQ-024 Alloc fire = alloc_valid & alloc_ready & !(ckpt_restore & ckpt_valid[ckpt_id]).
- On fire: r_ptr += alloc_cnt (mod DEPTH); free_count -= alloc_cnt.
- alloc_valid without alloc_ready: no state change.
REQ-025 Free lanes with free_valid=1 and free_tag!=0 SHALL be appended in ascending lane order at w_ptr, w_ptr+1, ...
- Lanes with tag 0 are ignored and consume no slot.
REQ-026 A free lane that would make free_count exceed DEPTH SHALL be dropped and SHALL set overflow_err until reset.
REQ-027 Same-cycle alloc and free SHALL both apply: free_count_next = free_count - allocated + accepted frees.
REQ-028 Save (without a valid restore in the same cycle):
- slot[ckpt_id].r_ptr = post-allocation r_ptr of this cycle;
- slot[ckpt_id].since = 0;
- ckpt_valid[ckpt_id] = 1.
- Saving into an already valid slot overwrites it.
REQ-029 Every valid slot not being written SHALL add this cycle's allocated count to its own since counter (width CNT_W, never exceeds DEPTH).
REQ-030 Restore with ckpt_valid[ckpt_id]=1:
- r_ptr = slot.r_ptr;
- free_count = free_count + slot.since + accepted frees;
- w_ptr advances by this cycle's frees only;
- a save in the same cycle is ignored.
REQ-031 On a valid restore:
- slot ckpt_id and slots in ckpt_kill SHALL be invalidated;
- each surviving valid slot SHALL have since reduced by the restored slot's since.
REQ-032 Restore with ckpt_valid[ckpt_id]=0 SHALL change no list or checkpoint state; normal alloc/free apply.
REQ-033 ckpt_release SHALL clear the masked valid bits after a same-cycle save. A save slot that is also in the release mask ends invalid.

Reset
REQ-034 When reset_n=0 at a clock edge:
- r_ptr=0, w_ptr=0, free_count=DEPTH, list[i]=NUM_AREGS+i;
- all ckpt_valid=0, all since=0, overflow_err=0.
REQ-035 After reset: alloc_ready=1, alloc_tag[i]=NUM_AREGS+i.
REQ-036 Reset asserted mid-operation SHALL override all same-cycle requests.

Verification
REQ-037 Reset, defaults -> free_count=96, alloc_tag[0]=32, alloc_tag[1]=33, alloc_ready=1, ckpt_valid=0.
REQ-038 alloc_cnt=2 for 48 cycles -> last grant is tags 126,127; free_count=0; alloc_ready=0. One more alloc_valid -> no change.
REQ-039 At free_count=94, free lanes tags {0,40} -> free_count=95; only 40 written at w_ptr; w_ptr+1.
REQ-040 Save slot 1 with alloc of 2 (tags 32,33), then 3 allocs of 2, then restore slot 1 -> free_count=94, alloc_tag[0]=34, ckpt_valid[1]=0.
REQ-041 Restore, alloc_valid and one free (tag 50) in the same cycle -> alloc ignored; free_count = pre + since + 1; tag 50 appended.
REQ-042 List full (96), free tag 60 -> dropped, overflow_err=1. Free 96 after draining all tags -> w_ptr wraps 95->0 correctly.
